hazard_scoreboard: RTL and testbench
====================================

# hazard_scoreboard

Parametrised hazard unit for the 5-stage pipeline. Replaces the single-cycle load-use check with a per-register load scoreboard that supports multi-cycle load latency. Adds a control-hazard FSM with a configurable branch penalty, a redirect/flush path, and saturating stall/flush performance counters. Sits beside the ID stage and drives the PC, IF/ID and ID/EX pipeline-register controls.

## Interface
- NUM_REGS, 32, architectural registers; register 0 is hardwired zero and never hazards
- REG_W, $clog2(NUM_REGS), register-index width
- OPC_W, 5, opcode width (instr[6:2])
- LOAD_LAT, 2, cycles after a load leaves EX before its result is forwardable; legal range ≥1
- BR_PENALTY, 1, extra PC-hold cycles after a control instruction leaves ID; legal range ≥0
- CNT_W, 16, performance counter width

Ports:
- clk  in  1  clock; all state updates on the rising edge
- reset  in  1  synchronous, active-high
- ID_Valid  in  1  ID holds a real instruction
- ID_Rs1, ID_Rs2  in  REG_W  ID source registers
- ID_UsesRs1, ID_UsesRs2  in  1  source is actually read
- ID_Opcode  in  OPC_W  ID opcode
- EX_Valid  in  1  EX holds a real instruction
- EX_MemRead  in  1  EX instruction is a load
- EX_Rd  in  REG_W  EX destination register
- Redirect  in  1  EX resolved a taken branch or jump
- PcWriteEn  out  1  PC may update
- IF_ID_WriteEn  out  1  IF/ID may load
- IF_ID_Flush  out  1  IF/ID loads a bubble
- ID_EX_Bubble  out  1  ID/EX loads a bubble
- StallCount  out  CNT_W  data-stall cycles, saturating
- FlushCount  out  CNT_W  redirect cycles, saturating

## Operation
- **Scoreboard:** one counter per register, width $clog2(LOAD_LAT)+1.
  - Load issue: when EX_Valid & EX_MemRead & EX_Rd≠0, the entry for EX_Rd loads LOAD_LAT−1 on the next edge.
  - Otherwise every nonzero entry decrements by 1 per cycle.
  - Load issue overrides decrement for the same register.
- **Source hazard:** a source is hazarded when all of the following hold:
  - ID_Valid, its UsesRsN bit, and Rs≠0;
  - and either (EX_Valid & EX_MemRead & EX_Rd==Rs) or sb[Rs]≠0.
- **DataHaz:** hazard on Rs1 or on Rs2.
- **Control opcode:** ID_Opcode ∈ {11011, 11000, 11001}, qualified with ID_Valid.
- **FSM states:**
  - RUN → CTRL_HOLD when a control opcode is in ID, DataHaz=0 and Redirect=0, and BR_PENALTY>0. Hold counter loads BR_PENALTY.
  - CTRL_HOLD: the hold counter decrements each cycle. The FSM returns to RUN when the counter is 1 or when Redirect is asserted.
- **Output priority:** reset > Redirect > DataHaz > control > normal.
  - Redirect: PcWriteEn=1, IF_ID_WriteEn=1, IF_ID_Flush=1, ID_EX_Bubble=1. Scoreboard is not cleared, because older loads still complete.
  - DataHaz: PcWriteEn=0, IF_ID_WriteEn=0, IF_ID_Flush=0, ID_EX_Bubble=1.
  - Control opcode in ID (RUN): PcWriteEn=0, IF_ID_WriteEn=1, IF_ID_Flush=1, ID_EX_Bubble=0.
  - CTRL_HOLD without Redirect: PcWriteEn=0, IF_ID_WriteEn=1, IF_ID_Flush=1, ID_EX_Bubble=0.
  - Normal: PcWriteEn=1, IF_ID_WriteEn=1, IF_ID_Flush=0, ID_EX_Bubble=0.
- **Counters:**
  - StallCount increments on cycles where DataHaz is asserted and Redirect is not.
  - FlushCount increments on cycles where Redirect is asserted.
  - Both saturate at all-ones and never wrap.

## Timing
- Control outputs are combinational from current inputs and registered state. No output is registered except the counters.
- Scoreboard, FSM and counters update on the rising edge of clk.
- A dependent instruction stalls for exactly LOAD_LAT cycles after its load enters EX, provided the dependent is in ID at that moment.
- Reset is synchronous. While reset=1 the outputs are:
  - PcWriteEn=0, IF_ID_WriteEn=0, IF_ID_Flush=1, ID_EX_Bubble=1.
- After the reset edge:
  - scoreboard is all 0;
  - FSM is in RUN;
  - hold counter is 0;
  - StallCount=0 and FlushCount=0.
- Reset during CTRL_HOLD or with scoreboard entries pending clears everything on that edge.
- Both sources matching the same pending register produce one stall per cycle, not two.
- A load with EX_Rd=0 never creates a scoreboard entry.
- With EX_Valid=0 the EX_MemRead input is ignored.

## Test plan
- Defaults; load x5 in EX, ID reads x5 (UsesRs1=1) → ID_EX_Bubble=1 and PcWriteEn=0 for 2 consecutive cycles, released on the 3rd; StallCount=2.
- Load x0 in EX, ID reads x0 → no stall; scoreboard stays 0.
- Load x7, then an independent instruction, then ID reads x7 one cycle later → stall exactly 1 cycle, because sb[x7]=1 decrements to 0.
- Branch opcode 11000 in ID with no hazard → PcWriteEn=0 with IF_ID_Flush=1 for 1 cycle, then CTRL_HOLD for 1 cycle, then RUN with PcWriteEn=1.
- Redirect=1 while DataHaz=1 and in CTRL_HOLD → IF_ID_Flush=1, PcWriteEn=1; FSM returns to RUN next cycle; FlushCount increments by 1 and StallCount does not change.
- CNT_W=4 with 20 forced stall cycles → StallCount holds at 15. Then assert reset for 1 cycle with sb entries pending → all counters and the scoreboard read 0 on the following cycle.

Source files
------------

// File: rtl/hazard_scoreboard.sv
// Hazard unit beside ID: per-register load scoreboard, control-hazard hold FSM,
// redirect flush path and saturating stall/flush counters.
module hazard_scoreboard #(
   parameter int unsigned NUM_REGS   = 32,
   parameter int unsigned REG_W      = $clog2(NUM_REGS),
   parameter int unsigned OPC_W      = 5,
   parameter int unsigned LOAD_LAT   = 2,
   parameter int unsigned BR_PENALTY = 1,
   parameter int unsigned CNT_W      = 16
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             ID_Valid,
   input  logic [REG_W-1:0] ID_Rs1,
   input  logic [REG_W-1:0] ID_Rs2,
   input  logic             ID_UsesRs1,
   input  logic             ID_UsesRs2,
   input  logic [OPC_W-1:0] ID_Opcode,
   input  logic             EX_Valid,
   input  logic             EX_MemRead,
   input  logic [REG_W-1:0] EX_Rd,
   input  logic             Redirect,
   output logic             PcWriteEn,
   output logic             IF_ID_WriteEn,
   output logic             IF_ID_Flush,
   output logic             ID_EX_Bubble,
   output logic [CNT_W-1:0] StallCount,
   output logic [CNT_W-1:0] FlushCount
);

   localparam int unsigned SB_W   = $clog2(LOAD_LAT) + 1;
   localparam int unsigned HOLD_W = (BR_PENALTY > 0) ? $clog2(BR_PENALTY + 1) : 1;
   localparam bit          HOLD_EN = (BR_PENALTY != 0);

   localparam logic [OPC_W-1:0] OPC_JAL    = OPC_W'(5'b11011);
   localparam logic [OPC_W-1:0] OPC_BRANCH = OPC_W'(5'b11000);
   localparam logic [OPC_W-1:0] OPC_JALR   = OPC_W'(5'b11001);

   typedef enum logic {RUN, CTRL_HOLD} state_t;

   state_t              state_q, state_d;
   logic [HOLD_W-1:0]   hold_q, hold_d;
   logic [SB_W-1:0]     sb_q [NUM_REGS];
   logic [CNT_W-1:0]    stall_cnt_q, flush_cnt_q;

   logic ex_load, ex_load_wr;
   logic haz_rs1, haz_rs2, data_haz, is_ctrl;

   // A load in EX hazards immediately; the scoreboard covers the cycles after it leaves EX.
   assign ex_load    = EX_Valid & EX_MemRead;
   assign ex_load_wr = ex_load & (EX_Rd != '0);

   assign haz_rs1 = ID_Valid & ID_UsesRs1 & (ID_Rs1 != '0) &
                    ((ex_load & (EX_Rd == ID_Rs1)) | (sb_q[ID_Rs1] != '0));
   assign haz_rs2 = ID_Valid & ID_UsesRs2 & (ID_Rs2 != '0) &
                    ((ex_load & (EX_Rd == ID_Rs2)) | (sb_q[ID_Rs2] != '0));
   assign data_haz = haz_rs1 | haz_rs2;

   assign is_ctrl = ID_Valid & ((ID_Opcode == OPC_JAL) | (ID_Opcode == OPC_BRANCH) |
                                (ID_Opcode == OPC_JALR));

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= RUN;
         hold_q  <= '0;
      end else begin
         state_q <= state_d;
         hold_q  <= hold_d;
      end
   end

   // Next-state and pipeline controls; priority reset > redirect > data hazard > control.
   always_comb begin
      state_d       = state_q;
      hold_d        = hold_q;
      PcWriteEn     = 1'b1;
      IF_ID_WriteEn = 1'b1;
      IF_ID_Flush   = 1'b0;
      ID_EX_Bubble  = 1'b0;

      case (state_q)
         RUN: begin
            if (is_ctrl && !data_haz && !Redirect && HOLD_EN) begin
               state_d = CTRL_HOLD;
               hold_d  = HOLD_W'(BR_PENALTY);
            end
         end
         CTRL_HOLD: begin
            if (hold_q != '0)
               hold_d = hold_q - HOLD_W'(1);
            if ((hold_q == HOLD_W'(1)) || Redirect) begin
               state_d = RUN;
               hold_d  = '0;
            end
         end
         default: begin
            state_d = RUN;
            hold_d  = '0;
         end
      endcase

      if (reset) begin
         PcWriteEn     = 1'b0;
         IF_ID_WriteEn = 1'b0;
         IF_ID_Flush   = 1'b1;
         ID_EX_Bubble  = 1'b1;
      end else if (Redirect) begin
         IF_ID_Flush   = 1'b1;
         ID_EX_Bubble  = 1'b1;
      end else if (data_haz) begin
         PcWriteEn     = 1'b0;
         IF_ID_WriteEn = 1'b0;
         ID_EX_Bubble  = 1'b1;
      end else if ((is_ctrl && (state_q == RUN)) || (state_q == CTRL_HOLD)) begin
         PcWriteEn     = 1'b0;
         IF_ID_Flush   = 1'b1;
      end
   end

   // Scoreboard: a new load overrides the countdown for its register; x0 is never loaded.
   always_ff @(posedge clk) begin
      if (reset) begin
         for (int i = 0; i < NUM_REGS; i++)
            sb_q[i] <= '0;
      end else begin
         for (int i = 0; i < NUM_REGS; i++) begin
            if (ex_load_wr && (EX_Rd == REG_W'(i)))
               sb_q[i] <= SB_W'(LOAD_LAT - 1);
            else if (sb_q[i] != '0)
               sb_q[i] <= sb_q[i] - SB_W'(1);
         end
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         stall_cnt_q <= '0;
         flush_cnt_q <= '0;
      end else begin
         if (data_haz && !Redirect && (stall_cnt_q != '1))
            stall_cnt_q <= stall_cnt_q + CNT_W'(1);
         if (Redirect && (flush_cnt_q != '1))
            flush_cnt_q <= flush_cnt_q + CNT_W'(1);
      end
   end

   assign StallCount = stall_cnt_q;
   assign FlushCount = flush_cnt_q;

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Directed bench for hazard_scoreboard with a 4-bit counter instance.
module tb_hazard_scoreboard;

   localparam int unsigned REG_W = 5;
   localparam int unsigned CNT_W = 4;

   logic             clk = 1'b0;
   logic             reset;
   logic             ID_Valid;
   logic [REG_W-1:0] ID_Rs1, ID_Rs2;
   logic             ID_UsesRs1, ID_UsesRs2;
   logic [4:0]       ID_Opcode;
   logic             EX_Valid, EX_MemRead;
   logic [REG_W-1:0] EX_Rd;
   logic             Redirect;
   logic             PcWriteEn, IF_ID_WriteEn, IF_ID_Flush, ID_EX_Bubble;
   logic [CNT_W-1:0] StallCount, FlushCount;

   int checks = 0;
   int errors = 0;

   hazard_scoreboard #(.CNT_W(CNT_W)) dut (
      .clk           (clk),
      .reset         (reset),
      .ID_Valid      (ID_Valid),
      .ID_Rs1        (ID_Rs1),
      .ID_Rs2        (ID_Rs2),
      .ID_UsesRs1    (ID_UsesRs1),
      .ID_UsesRs2    (ID_UsesRs2),
      .ID_Opcode     (ID_Opcode),
      .EX_Valid      (EX_Valid),
      .EX_MemRead    (EX_MemRead),
      .EX_Rd         (EX_Rd),
      .Redirect      (Redirect),
      .PcWriteEn     (PcWriteEn),
      .IF_ID_WriteEn (IF_ID_WriteEn),
      .IF_ID_Flush   (IF_ID_Flush),
      .ID_EX_Bubble  (ID_EX_Bubble),
      .StallCount    (StallCount),
      .FlushCount    (FlushCount)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   task automatic chk_ctl(input string tag, input logic pc, input logic we,
                          input logic fl, input logic bub);
      chk({tag, ".pc"},  32'(PcWriteEn),     32'(pc));
      chk({tag, ".we"},  32'(IF_ID_WriteEn), 32'(we));
      chk({tag, ".fl"},  32'(IF_ID_Flush),   32'(fl));
      chk({tag, ".bub"}, 32'(ID_EX_Bubble),  32'(bub));
   endtask

   task automatic idle();
      ID_Valid = 1'b0; ID_Rs1 = '0; ID_Rs2 = '0; ID_UsesRs1 = 1'b0; ID_UsesRs2 = 1'b0;
      ID_Opcode = 5'b01100; EX_Valid = 1'b0; EX_MemRead = 1'b0; EX_Rd = '0; Redirect = 1'b0;
   endtask

   task automatic ex_load(input logic [REG_W-1:0] rd);
      EX_Valid = 1'b1; EX_MemRead = 1'b1; EX_Rd = rd;
   endtask

   task automatic id_reads(input logic [REG_W-1:0] rs1, input logic u1,
                           input logic [REG_W-1:0] rs2, input logic u2);
      ID_Valid = 1'b1; ID_Rs1 = rs1; ID_UsesRs1 = u1; ID_Rs2 = rs2; ID_UsesRs2 = u2;
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   initial begin
      reset = 1'b1;
      idle();
      #1;
      chk_ctl("reset_out", 1'b0, 1'b0, 1'b1, 1'b1);
      tick();
      reset = 1'b0;
      #1;
      chk_ctl("post_reset", 1'b1, 1'b1, 1'b0, 1'b0);
      chk("post_reset.stall", 32'(StallCount), 32'd0);
      chk("post_reset.flush", 32'(FlushCount), 32'd0);

      // load x5 then dependent read: two stall cycles
      ex_load(5'd5); id_reads(5'd5, 1'b1, 5'd0, 1'b0); #1;
      chk_ctl("lu_c0", 1'b0, 1'b0, 1'b0, 1'b1);
      tick();
      EX_Valid = 1'b0; EX_MemRead = 1'b0; #1;
      chk_ctl("lu_c1", 1'b0, 1'b0, 1'b0, 1'b1);
      tick();
      chk_ctl("lu_c2", 1'b1, 1'b1, 1'b0, 1'b0);
      chk("lu.stall", 32'(StallCount), 32'd2);
      idle(); tick();

      // load to x0 never hazards
      ex_load(5'd0); id_reads(5'd0, 1'b1, 5'd0, 1'b1); #1;
      chk_ctl("x0_c0", 1'b1, 1'b1, 1'b0, 1'b0);
      tick();
      idle(); #1;
      chk("x0.stall", 32'(StallCount), 32'd2);

      // EX_MemRead ignored without EX_Valid
      EX_MemRead = 1'b1; EX_Rd = 5'd4; id_reads(5'd4, 1'b1, 5'd0, 1'b0); #1;
      chk_ctl("exinv_c0", 1'b1, 1'b1, 1'b0, 1'b0);
      tick();
      chk_ctl("exinv_c1", 1'b1, 1'b1, 1'b0, 1'b0);
      idle(); tick();

      // load x7, independent, then read x7 via Rs2: one stall
      ex_load(5'd7); id_reads(5'd3, 1'b1, 5'd0, 1'b0); #1;
      chk_ctl("x7_c0", 1'b1, 1'b1, 1'b0, 1'b0);
      tick();
      idle(); id_reads(5'd0, 1'b0, 5'd7, 1'b1); #1;
      chk_ctl("x7_c1", 1'b0, 1'b0, 1'b0, 1'b1);
      tick();
      chk_ctl("x7_c2", 1'b1, 1'b1, 1'b0, 1'b0);
      chk("x7.stall", 32'(StallCount), 32'd3);
      idle(); tick();

      // branch: one cycle in ID, one hold cycle, then run
      ID_Valid = 1'b1; ID_Opcode = 5'b11000; #1;
      chk_ctl("br_c0", 1'b0, 1'b1, 1'b1, 1'b0);
      tick();
      idle(); #1;
      chk_ctl("br_hold", 1'b0, 1'b1, 1'b1, 1'b0);
      tick();
      chk_ctl("br_run", 1'b1, 1'b1, 1'b0, 1'b0);

      // jal opcode also a control hazard
      ID_Valid = 1'b1; ID_Opcode = 5'b11011; #1;
      chk("jal.pc", 32'(PcWriteEn), 32'd0);
      tick();
      idle(); tick();

      // redirect while in hold with a data hazard present
      ID_Valid = 1'b1; ID_Opcode = 5'b11001; #1;
      tick();
      idle(); ex_load(5'd9); id_reads(5'd9, 1'b1, 5'd9, 1'b1); Redirect = 1'b1; #1;
      chk_ctl("redir", 1'b1, 1'b1, 1'b1, 1'b1);
      tick();
      idle(); #1;
      chk_ctl("redir_run", 1'b1, 1'b1, 1'b0, 1'b0);
      chk("redir.flush", 32'(FlushCount), 32'd1);
      chk("redir.stall", 32'(StallCount), 32'd3);
      tick();

      // 20 stall cycles saturate the 4-bit counter (both sources hit: one count per cycle)
      ex_load(5'd5); id_reads(5'd5, 1'b1, 5'd5, 1'b1);
      for (int i = 0; i < 20; i++) tick();
      chk("sat.stall", 32'(StallCount), 32'd15);
      EX_Valid = 1'b0; EX_MemRead = 1'b0; #1;
      chk_ctl("sat_pending", 1'b0, 1'b0, 1'b0, 1'b1);

      // reset with x5 pending clears scoreboard and counters
      reset = 1'b1; idle(); tick();
      reset = 1'b0; id_reads(5'd5, 1'b1, 5'd0, 1'b0); #1;
      chk_ctl("rst_sb", 1'b1, 1'b1, 1'b0, 1'b0);
      chk("rst.stall", 32'(StallCount), 32'd0);
      chk("rst.flush", 32'(FlushCount), 32'd0);
      idle(); tick();

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL timeout: observed=running expected=finished");
      $fatal(1, "timeout");
   end

endmodule
